period_meter: RTL
=================

PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the bit width of the period count and result.
REQ-002 SHALL have parameter TIMEOUT, default 4_000_000, giving the cycle count without an edge after which measurement is abandoned.
REQ-003 SHALL have parameter LOCK_TOL, default 2, giving the maximum |difference| in cycles between consecutive periods counted as matching (used only with REQ-026).
REQ-004 clk_in  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst_in  input  1  asynchronous, active-low reset.
REQ-006 sig_in  input  1  asynchronous periodic signal to be measured.
REQ-007 period_out  output  WIDTH  last measured period in clk_in cycles.
REQ-008 valid_out  output  1  one-cycle pulse when period_out updates.
REQ-009 timeout_out  output  1  one-cycle pulse when TIMEOUT is reached without an edge.
REQ-010 lock_out  output  1  stable-period indicator (REQ-026); tied 0 when the feature is excluded.

Function
REQ-011 sig_in SHALL pass through a 2-flop synchronizer; a rising edge is detected when the synchronized value is 1 and its one-cycle-delayed copy is 0.
REQ-012 The state machine SHALL have two states: IDLE, which waits for the first edge, and MEASURE, which counts between edges.
REQ-013 IDLE + edge -> MEASURE; cycle counter cleared to 0; no valid_out.
REQ-014 In MEASURE, the counter SHALL increment by 1 every cycle with no edge.
REQ-015 MEASURE + edge SHALL, on the next clk_in edge, load period_out with the counter value plus 1, pulse valid_out for 1 cycle, and clear the counter; state stays MEASURE.
REQ-016 A square wave of period P cycles SHALL yield period_out = P; valid_out SHALL rise exactly 3 clk_in cycles after the first cycle sig_in is sampled high.
REQ-017 MEASURE + counter+1 == TIMEOUT + no edge SHALL pulse timeout_out for 1 cycle, return to IDLE, and keep period_out unchanged.
REQ-018 If an edge and the timeout occur in the same cycle, the edge SHALL win: REQ-015 applies and timeout_out stays 0.
REQ-019 The counter SHALL never wrap; TIMEOUT SHALL be <= 2^WIDTH-1, checked at elaboration.
REQ-020 Edges closer than 2 cycles are not resolvable; the minimum reported period SHALL be 2.
REQ-021 valid_out and timeout_out SHALL never both be 1 in the same cycle.

Reset
REQ-022 rst_in low SHALL immediately force state IDLE and set counter, synchronizer flops, period_out, valid_out, timeout_out and lock_out to 0.
REQ-023 After rst_in deasserts, the first detected edge SHALL only arm measurement (REQ-013); the first valid_out follows the second edge.
REQ-024 Reset asserted mid-measurement SHALL discard the partial count; no valid_out or timeout_out pulse SHALL result.

Configuration
REQ-025 Macro PERIOD_METER_LOCK_EN SHALL control whether the period-lock detector is compiled in.
REQ-026 With the macro defined: on each valid_out, lock_out SHALL be set to 1 if |new period - previous period| <= LOCK_TOL, else 0; it updates in the same cycle as period_out, and is cleared on timeout and on reset.
REQ-027 With the macro undefined: lock_out SHALL be constant 0 and no previous-period register SHALL exist.

Verification
REQ-028 Reset, then a 10-cycle square wave on sig_in -> no valid_out after the first edge; valid_out with period_out = 10 after each later edge.
REQ-029 Period changes from 10 to 25 -> the next valid_out reports 25 with no intermediate value.
REQ-030 TIMEOUT = 50, sig_in held low after one edge -> timeout_out pulses 50 cycles after that edge; period_out is unchanged; the next edge gives no valid_out.
REQ-031 Edge arriving on the timeout cycle (gap = 50, TIMEOUT = 50) -> valid_out with period_out = 50 and timeout_out = 0.
REQ-032 rst_in pulsed low mid-period -> all outputs are 0 immediately; no pulses follow; the next two edges are needed for valid_out.
REQ-033 With PERIOD_METER_LOCK_EN defined and periods 100, 101, 104 -> lock_out goes 0 after the first result, 1 after 101, and 0 after 104.

Source files
------------

// File: rtl/period_meter.sv
// period_meter
//   Measures the period of an asynchronous input in clk_in cycles. The first
//   rising edge after reset or after a timeout only arms the measurement;
//   every later rising edge reports the number of cycles since the edge before.
//
//   Optional feature: define PERIOD_METER_LOCK_EN to compile in the
//   period-lock detector that drives lock_out. Without it, lock_out is tied 0.
//
//   Parameters
//     WIDTH     width of the cycle counter and period_out
//     TIMEOUT   cycles without an edge after which measurement is abandoned
//     LOCK_TOL  largest |difference| between consecutive periods that counts
//               as locked
//
//   Ports
//     clk_in       system clock, rising edge
//     rst_in       asynchronous reset, active low
//     sig_in       asynchronous signal being measured
//     period_out   last measured period in clk_in cycles
//     valid_out    one-cycle pulse when period_out updates
//     timeout_out  one-cycle pulse when TIMEOUT cycles pass without an edge
//     lock_out     consecutive periods agree within LOCK_TOL
//
//   Latency: a rising edge on sig_in first sampled on clock n is acted on at
//   clock n+3 (2 synchronizer flops + registered edge pulse).
//
//   state   | meaning
//   IDLE    | waiting for the arming edge, counter held at 0
//   MEASURE | counting cycles since the last edge

module period_meter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned TIMEOUT  = 4_000_000,
  parameter int unsigned LOCK_TOL = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period_out,
  output logic             valid_out,
  output logic             timeout_out,
  output logic             lock_out
);

  // The counter is bounded by TIMEOUT-1, so TIMEOUT must fit in WIDTH bits.
  if ((64'(TIMEOUT) >> WIDTH) != 64'd0) begin : g_bad_timeout
    $error("period_meter: TIMEOUT does not fit in WIDTH bits");
  end
  if (TIMEOUT < 2) begin : g_small_timeout
    $error("period_meter: TIMEOUT must be at least 2");
  end
  // A tolerance at or above TIMEOUT would match any pair of periods.
  if (LOCK_TOL >= TIMEOUT) begin : g_bad_tol
    $error("period_meter: LOCK_TOL must be below TIMEOUT");
  end

  localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic             sync1, sync2, sync3;
  logic             edge_q;
  logic [WIDTH-1:0] cnt, cnt_nxt, cnt_inc;
  logic [WIDTH-1:0] period_nxt;
  logic             valid_nxt, timeout_nxt;

  // Synchronizer, one-cycle delayed copy, and a registered rising-edge pulse.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync1  <= sig_in;
      sync2  <= sync1;
      sync3  <= sync2;
      edge_q <= sync2 & ~sync3;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    period_nxt  = period_out;
    valid_nxt   = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (edge_q) begin
          state_nxt = MEASURE;
        end
      end
      MEASURE: begin
        // An edge on the timeout cycle still yields a result.
        if (edge_q) begin
          period_nxt = cnt_inc;
          valid_nxt  = 1'b1;
          cnt_nxt    = '0;
        end else if (cnt_inc == TIMEOUT_W) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt         <= '0;
      period_out  <= '0;
      valid_out   <= 1'b0;
      timeout_out <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      period_out  <= period_nxt;
      valid_out   <= valid_nxt;
      timeout_out <= timeout_nxt;
    end
  end

`ifdef PERIOD_METER_LOCK_EN
  localparam logic [WIDTH-1:0] TOL_W = WIDTH'(LOCK_TOL);

  // period_out still holds the previous result when a new one is computed,
  // so it doubles as the previous-period value. have_prev keeps the very
  // first result after reset from being compared against the reset value.
  logic             have_prev;
  logic [WIDTH-1:0] diff;
  logic             lock_nxt;

  always_comb begin
    diff = (cnt_inc >= period_out) ? (cnt_inc - period_out)
                                   : (period_out - cnt_inc);
    lock_nxt = lock_out;
    if (valid_nxt) begin
      lock_nxt = have_prev && (diff <= TOL_W);
    end else if (timeout_nxt) begin
      lock_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      lock_out  <= 1'b0;
      have_prev <= 1'b0;
    end else begin
      lock_out <= lock_nxt;
      if (valid_nxt) begin
        have_prev <= 1'b1;
      end
    end
  end
`else
  assign lock_out = 1'b0;
`endif

endmodule
